// File: rtl/lzx_nibble_adder_seq.sv
// lzx_nibble_adder_seq: wide add/subtract built from a single 4-bit adder slice.
// The operands are processed one nibble per clock, LSB first. The ripple carry
// is held in a register between nibbles.
// Optional feature macro: LZX_SEQ_OVF_EN. When it is defined, ovf reports
// signed overflow. When it is undefined, ovf is tied to 0.

// 4-bit carry-lookahead adder slice with the same function as a 74HC283.
// c_o[k] is the carry into bit k. c_o[0] equals c0_i.
module lzx_74HC283 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c0_i,
    output logic [3:0] s_o,
    output logic       c4_o,
    output logic [3:0] c_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       c1_s;
    logic       c2_s;
    logic       c3_s;
    logic       c4_s;

    // Bitwise generate/propagate and flat lookahead carries (no internal ripple loop)
    always_comb begin
        g_s  = a_i & b_i;
        p_s  = a_i ^ b_i;
        c1_s = g_s[0] | (p_s[0] & c0_i);
        c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c0_i);
        c3_s = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & c0_i);
        c4_s = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c0_i);
        s_o  = p_s ^ {c3_s, c2_s, c1_s, c0_i};
        c4_o = c4_s;
        c_o  = {c3_s, c2_s, c1_s, c0_i};
        g_o  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        p_o  = &p_s;
    end

endmodule

module lzx_nibble_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   sum_q;
    logic           cout_q;
    logic           ready_q;
    logic           busy_q;
    logic           done_q;

    logic           accept_s;
    logic [3:0]     slice_a_s;
    logic [3:0]     slice_b_s;
    logic [3:0]     slice_s_s;
    logic           slice_cout_s;
    // Only bit 3 (carry into the MSB) is consumed, and only for overflow.
    logic [3:0]     adder_c_unused_s;
    logic           adder_g_unused_s;
    logic           adder_p_unused_s;

    assign accept_s = start & ready_q;

    // Select the current nibble of each captured operand for the slice
    always_comb begin
        slice_a_s = a_q[{idx_q, 2'b00} +: 4];
        slice_b_s = b_q[{idx_q, 2'b00} +: 4];
    end

    lzx_74HC283 u_slice (
        .a_i  (slice_a_s),
        .b_i  (slice_b_s),
        .c0_i (carry_q),
        .s_o  (slice_s_s),
        .c4_o (slice_cout_s),
        .c_o  (adder_c_unused_s),
        .g_o  (adder_g_unused_s),
        .p_o  (adder_p_unused_s)
    );

`ifdef LZX_SEQ_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Sequencer FSM with its datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LZX_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        // Subtraction runs as A + ~B + ~borrow.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? ~cin : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef LZX_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= slice_s_s;
                    carry_q <= slice_cout_s;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_cout_s;
`ifdef LZX_SEQ_OVF_EN
                        ovf_q   <= adder_c_unused_s[3] ^ slice_cout_s;
`endif
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_lzx_nibble_adder_seq.sv
// Self-checking bench for lzx_nibble_adder_seq (NIBBLES=4). Expected results
// are queued when an operation is started and popped when done pulses.
module tb_lzx_nibble_adder_seq;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   checks;
    int   failures;

    lzx_nibble_adder_seq #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ovf_exp(input logic v);
`ifdef LZX_SEQ_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one request; accepted at the next rising edge. Inputs are then scrambled.
    task automatic op_start(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv, input exp_t e, input bit push);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_ready", 64'(ready), 64'd0);
        chk("accept_sum_cleared", 64'(sum), 64'd0);
    endtask

    // Wait (bounded) for done, check latency, pop and compare the result.
    task automatic wait_done(input string name, input int exp_lat);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < exp_lat + 10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else cyc++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done actual=done required=no_done", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
            chk({name, "_sum"}, 64'(sum), 64'(e.sum));
            chk({name, "_cout"}, 64'(cout), 64'(e.cout));
            chk({name, "_ovf"}, 64'(ovf), 64'(e.ovf));
            chk({name, "_ready_in_done"}, 64'(ready), 64'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   dcount;
        checks = 0;
        failures = 0;

        vecs[0]  = '{"add_carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{"add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{"add_cin",         16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[3]  = '{"sub_neg",         16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{"sub_borrow_in",   16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};
        vecs[5]  = '{"add_pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6]  = '{"sub_neg_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{"add_plain",       16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[8]  = '{"sub_zero",        16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{"sub_zero_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{"add_min_min",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[11] = '{"add_m1_m1_cin",   16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);

        // Table-driven operations, each started from IDLE.
        for (int i = 0; i < 12; i++) begin
            e.sum = vecs[i].es; e.cout = vecs[i].ec; e.ovf = ovf_exp(vecs[i].eo);
            op_start(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, e, 1'b1);
            wait_done(vecs[i].name, NIBBLES);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_idle_ready"}, 64'(ready), 64'd1);
            chk({vecs[i].name, "_idle_done"}, 64'(done), 64'd0);
            chk({vecs[i].name, "_held_sum"}, 64'(sum), 64'(vecs[i].es));
        end

        // Start while busy is ignored.
        e.sum = 16'h2345; e.cout = 1'b0; e.ovf = 1'b0;
        op_start(16'h1234, 16'h1111, 1'b0, 1'b0, e, 1'b1);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("midrun_ignored", NIBBLES - 1);
        @(posedge clk);
        #1;

        // Back-to-back: start accepted in the DONE cycle.
        e.sum = 16'h1111; e.cout = 1'b0; e.ovf = 1'b0;
        op_start(16'h0F0F, 16'h0202, 1'b0, 1'b0, e, 1'b1);
        wait_done("b2b_first", NIBBLES);
        e.sum = 16'h0FFF; e.cout = 1'b1; e.ovf = 1'b0;
        op_start(16'h1000, 16'h0001, 1'b1, 1'b0, e, 1'b1);
        wait_done("b2b_second", NIBBLES);
        @(posedge clk);
        #1;

        // Reset two cycles into RUN abandons the operation.
        e.sum = 16'hAAAA; e.cout = 1'b0; e.ovf = 1'b0;
        op_start(16'h5555, 16'h5555, 1'b0, 1'b0, e, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        @(posedge clk);
        #1;
        e.sum = 16'h0011; e.cout = 1'b1; e.ovf = 1'b0;
        op_start(16'hFFF0, 16'h0020, 1'b0, 1'b1, e, 1'b1);
        wait_done("after_reset", NIBBLES);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lzx_nibble_adder_seq.md
Name: lzx_nibble_adder_seq

Overview:
- Multi-cycle sequencer that time-shares one lzx_74HC283 4-bit adder slice to add or subtract wide operands, one nibble per clock, LSB first.
- Holds the ripple carry in a register between nibbles.
- Sits between a host issuing start/operands and the single adder slice, which is instantiated inside this block.
- Gives gate-level designs wide arithmetic at the cost of one 4-bit adder.

Parameters:
- NIBBLES, 4, operand width in nibbles (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only when ready
- sub  input  1  0 = A+B+cin; 1 = A-B-cin (cin acts as borrow-in)
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cin  input  1  carry-in / borrow-in, captured on accepted start
- ready  output  1  high in IDLE and DONE (start accepted)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result valid
- sum  output  W  result; held until the next accepted start
- cout  output  1  final carry (sub: 1 = no borrow); held with sum
- ovf  output  1  signed overflow (only with the optional feature)

Behaviour:
- Reset (rst=1 at a clk edge) returns to IDLE from any state. After reset: ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. Operand, carry and index registers = 0.
- States:
  - IDLE -> RUN on start.
  - RUN stays in RUN while idx < NIBBLES-1; RUN -> DONE when idx = NIBBLES-1.
  - DONE -> RUN on start; DONE -> IDLE otherwise.
- Accept (start=1 while ready=1):
  - areg = a; breg = sub ? ~b : b.
  - carry = sub ? ~cin : cin.
  - idx = 0; sum cleared to 0; cout and ovf cleared.
- RUN, each cycle:
  - The adder gets A = areg[4idx+3:4idx], B = breg[4idx+3:4idx], Cin = carry.
  - sum[4idx+3:4idx] = S; carry = Cout; idx increments.
  - The adder is purely combinational; one nibble completes per cycle.
- Entry to DONE: cout = carry after the last nibble; done = 1 for exactly the DONE cycle.
- Latency: start accepted at edge t; RUN occupies edges t+1..t+NIBBLES; done is high in the cycle following edge t+NIBBLES.
  - NIBBLES=4: done asserts 5 cycles after the start edge.
- start while busy=1 is ignored; no queuing, no error flag.
- start in the DONE cycle is accepted (back-to-back). done still pulses that cycle. The previous sum is visible only during that cycle.
- rst mid-RUN: the operation is abandoned, no done pulse, sum and cout cleared.
- a, b, cin and sub may change freely after acceptance; only the captured copies are used.
- Width rules:
  - sum is exactly W bits. The carry out of the MSB nibble goes only to cout.
  - No saturation.
  - Subtraction is two's-complement A + ~B + ~cin.
- Adder G/P/C outputs are left unconnected; only S and Cout are used.

Optional Feature:
- Macro: LZX_SEQ_OVF_EN.
- Defined:
  - During the final RUN cycle, ovf = carry into MSB XOR carry out of MSB, i.e. adder C[3] XOR Cout on nibble NIBBLES-1.
  - ovf is latched with cout and held until the next accept.
- Undefined: the ovf port is still present and tied to 0; no extra logic.

Test Plan:
- Reset, then NIBBLES=4, a=0x00FF, b=0x0001, sub=0, cin=0, start pulse -> busy for 4 cycles, done pulse 5 cycles after start, sum=0x0100, cout=0.
- a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1; then a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0.
- sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0. Then sub=1, a=0x0009, b=0x0003, cin=1 -> sum=0x0005, cout=1.
- With LZX_SEQ_OVF_EN: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1. Without the macro, ovf=0 for both.
- Second start mid-RUN with different operands -> ignored, first result unchanged. Start asserted during the done cycle -> accepted, second result arrives 5 cycles later.
- rst=1 two cycles into RUN -> next cycle busy=0, ready=1, sum=0, cout=0, no done pulse; a following start completes normally.
